vsdma_wr_arbiter: RTL and testbench

VSDMA_WR_ARBITER -- requirements
Module: vsdma_wr_arbiter

---
 rtl/vsdma_wr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_vsdma_wr_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsdma_wr_arbiter.sv
// ---------------------------------------------------------------------------
// vsdma_wr_arbiter
// Round-robin arbiter that lets N_PORTS write requesters share a single
// vsdma_to_axi write channel. A port raises s_wareq with its burst address
// and beat count, gets granted, and then streams its data through to the
// shared channel until the channel drops m_wbusy. A sticky flag reports any
// burst whose accepted beat count differed from the size it asked for.
//
// Ports:
//   ui_clk, ui_rst        clock and asynchronous active-high reset
//   s_wareq/s_waddr/s_wsize  per-port burst requests (packed per port)
//   s_wbusy               busy indication back to the granted port
//   s_wdata/s_wvalid      per-port write data
//   s_wready              per-port data ready (only the granted port's bit moves)
//   m_wareq/m_waddr/m_wsize  burst request to the shared write channel
//   m_wbusy               shared channel burst-in-progress
//   m_wdata/m_wvalid/m_wready  shared data path
//   grant_id              current or most recently granted port
//   err_beats             sticky beat-count mismatch flag
// ---------------------------------------------------------------------------
module vsdma_wr_arbiter #(
   parameter int N_PORTS    = 4,
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 256,
   parameter int SIZE_WIDTH = 16
) (
   input  logic                            ui_clk,
   input  logic                            ui_rst,
   input  logic [N_PORTS-1:0]              s_wareq,
   input  logic [N_PORTS*ADDR_WIDTH-1:0]   s_waddr,
   input  logic [N_PORTS*SIZE_WIDTH-1:0]   s_wsize,
   output logic [N_PORTS-1:0]              s_wbusy,
   input  logic [N_PORTS*DATA_WIDTH-1:0]   s_wdata,
   input  logic [N_PORTS-1:0]              s_wvalid,
   output logic [N_PORTS-1:0]              s_wready,
   output logic [ADDR_WIDTH-1:0]           m_waddr,
   output logic                            m_wareq,
   output logic [SIZE_WIDTH-1:0]           m_wsize,
   input  logic                            m_wbusy,
   output logic [DATA_WIDTH-1:0]           m_wdata,
   output logic                            m_wvalid,
   input  logic                            m_wready,
   output logic [$clog2(N_PORTS)-1:0]      grant_id,
   output logic                            err_beats
);

   localparam int GW = $clog2(N_PORTS);

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

   state_t                state;
   state_t                state_next;
   logic [GW-1:0]         last_grant;
   logic [GW-1:0]         winner;
   logic                  any_req;
   int unsigned           cand;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [SIZE_WIDTH-1:0] lat_size;
   logic [SIZE_WIDTH-1:0] beat_cnt;
   logic [SIZE_WIDTH-1:0] beat_cnt_next;
   logic                  beat_fire;

   // Round-robin pick. The search walks from the farthest candidate back to
   // last_grant+1 so that the nearest asserted request is the one left in
   // winner when the loop finishes.
   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      cand    = 0;
      for (int k = N_PORTS; k >= 1; k--) begin
         cand = (int'(last_grant) + k) % N_PORTS;
         if (s_wareq[cand]) begin
            winner  = GW'(cand);
            any_req = 1'b1;
         end
      end
   end

   // Burst state register. Reset drops straight back to IDLE so an aborted
   // burst never passes through DONE.
   always_ff @(posedge ui_clk or posedge ui_rst) begin
      if (ui_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs. Everything facing the ports is derived
   // from the state, so reset forces all handshakes low without a clock edge.
   // Only the granted port's s_wbusy/s_wready bits can ever be driven.
   always_comb begin
      state_next = state;
      m_wareq    = 1'b0;
      m_wvalid   = 1'b0;
      m_wdata    = '0;
      s_wbusy    = '0;
      s_wready   = '0;
      case (state)
         IDLE: begin
            if (!m_wbusy && any_req) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            m_wareq           = 1'b1;
            s_wbusy[grant_id] = 1'b1;
            if (m_wbusy) begin
               state_next = BUSY;
            end
         end
         BUSY: begin
            s_wbusy[grant_id]  = 1'b1;
            s_wready[grant_id] = m_wready;
            m_wvalid           = s_wvalid[grant_id];
            m_wdata            = s_wdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
            if (!m_wbusy) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign beat_fire     = (state == BUSY) && m_wvalid && m_wready;
   assign beat_cnt_next = beat_cnt + SIZE_WIDTH'(beat_fire);
   assign m_waddr       = lat_addr;
   assign m_wsize       = lat_size;

   // Grant bookkeeping and beat accounting. The address and size are captured
   // at grant time so the requester may change or withdraw them afterwards.
   // The beat check includes a beat landing on the same edge m_wbusy falls.
   // last_grant only advances in DONE, which is why an aborted burst leaves
   // the rotation where reset put it.
   always_ff @(posedge ui_clk or posedge ui_rst) begin
      if (ui_rst) begin
         grant_id   <= '0;
         last_grant <= GW'(N_PORTS - 1);
         lat_addr   <= '0;
         lat_size   <= '0;
         beat_cnt   <= '0;
         err_beats  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (state_next == ISSUE) begin
                  grant_id <= winner;
                  lat_addr <= s_waddr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                  lat_size <= s_wsize[int'(winner)*SIZE_WIDTH +: SIZE_WIDTH];
                  beat_cnt <= '0;
               end
            end
            BUSY: begin
               beat_cnt <= beat_cnt_next;
               if (!m_wbusy && (beat_cnt_next != lat_size)) begin
                  err_beats <= 1'b1;
               end
            end
            DONE: begin
               last_grant <= grant_id;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vsdma_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vsdma_wr_arbiter
// Self-checking bench for vsdma_wr_arbiter. The bench plays both the
// requesting ports and the shared write channel, and keeps a small model of
// the round-robin order and the sticky beat-error flag.
// ---------------------------------------------------------------------------
module tb_vsdma_wr_arbiter;

   localparam int N_PORTS    = 4;
   localparam int ADDR_WIDTH = 28;
   localparam int DATA_WIDTH = 256;
   localparam int SIZE_WIDTH = 16;

   logic                          ui_clk = 1'b0;
   logic                          ui_rst;
   logic [N_PORTS-1:0]            s_wareq;
   logic [N_PORTS*ADDR_WIDTH-1:0] s_waddr;
   logic [N_PORTS*SIZE_WIDTH-1:0] s_wsize;
   logic [N_PORTS-1:0]            s_wbusy;
   logic [N_PORTS*DATA_WIDTH-1:0] s_wdata;
   logic [N_PORTS-1:0]            s_wvalid;
   logic [N_PORTS-1:0]            s_wready;
   logic [ADDR_WIDTH-1:0]         m_waddr;
   logic                          m_wareq;
   logic [SIZE_WIDTH-1:0]         m_wsize;
   logic                          m_wbusy;
   logic [DATA_WIDTH-1:0]         m_wdata;
   logic                          m_wvalid;
   logic                          m_wready;
   logic [1:0]                    grant_id;
   logic                          err_beats;

   int check_count = 0;
   int pass_count  = 0;

   // Reference model state
   int                    model_last;
   bit                    model_err;
   logic [ADDR_WIDTH-1:0] model_addr [N_PORTS];
   logic [SIZE_WIDTH-1:0] model_size [N_PORTS];

   vsdma_wr_arbiter #(
      .N_PORTS(N_PORTS), .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH), .SIZE_WIDTH(SIZE_WIDTH)
   ) dut (
      .ui_clk(ui_clk), .ui_rst(ui_rst),
      .s_wareq(s_wareq), .s_waddr(s_waddr), .s_wsize(s_wsize), .s_wbusy(s_wbusy),
      .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .m_waddr(m_waddr), .m_wareq(m_wareq), .m_wsize(m_wsize), .m_wbusy(m_wbusy),
      .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .grant_id(grant_id), .err_beats(err_beats)
   );

   always #5 ui_clk = ~ui_clk;

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: observed timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
      check_count++;
      if (observed === expected) pass_count++;
      else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   // First requester found walking the ring from the port after the last grant.
   function automatic int rrPick(input logic [N_PORTS-1:0] req, input int last);
      for (int k = 1; k <= N_PORTS; k++) begin
         if (req[(last + k) % N_PORTS]) return (last + k) % N_PORTS;
      end
      return -1;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] randData();
      logic [DATA_WIDTH-1:0] d;
      for (int w = 0; w < DATA_WIDTH / 32; w++) d[w*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic setRequest(input int p, input logic [ADDR_WIDTH-1:0] a,
                             input logic [SIZE_WIDTH-1:0] s);
      model_addr[p] = a;
      model_size[p] = s;
      s_waddr[p*ADDR_WIDTH +: ADDR_WIDTH] = a;
      s_wsize[p*SIZE_WIDTH +: SIZE_WIDTH] = s;
      s_wareq[p] = 1'b1;
   endtask

   // Random data on every port and random channel readiness for one cycle.
   task automatic applyStimulus();
      for (int p = 0; p < N_PORTS; p++) begin
         s_wvalid[p] = 1'($urandom_range(0, 1));
         s_wdata[p*DATA_WIDTH +: DATA_WIDTH] = randData();
      end
      m_wready = 1'($urandom_range(0, 1));
   endtask

   task automatic clearInputs();
      s_wareq  = '0;
      s_wvalid = '0;
      m_wbusy  = 1'b0;
      m_wready = 1'b0;
   endtask

   task automatic doReset();
      ui_rst = 1'b1;
      clearInputs();
      @(negedge ui_clk);
      @(negedge ui_clk);
      checkOutput("rst_wareq", m_wareq, 0);
      checkOutput("rst_grant", grant_id, 0);
      checkOutput("rst_err", err_beats, 0);
      checkOutput("rst_sbusy", s_wbusy, 0);
      checkOutput("rst_addr", m_waddr, 0);
      ui_rst     = 1'b0;
      model_last = N_PORTS - 1;
      model_err  = 1'b0;
   endtask

   // Runs one burst starting from an IDLE negedge with requests already set.
   // beats < 0 means the channel accepts exactly the requested size.
   task automatic runBurst(input int beats, input bit abort_mid, output int granted);
      int exp_port;
      int accepted;
      int cycles;
      int want;
      logic [N_PORTS-1:0] one_hot;
      exp_port = rrPick(s_wareq, model_last);
      granted  = -1;
      if (exp_port < 0) begin
         checkOutput("no_request", 0, 1);
         return;
      end
      one_hot = '0;
      one_hot[exp_port] = 1'b1;
      want = (beats < 0) ? int'(model_size[exp_port]) : beats;
      @(negedge ui_clk);
      granted = int'(grant_id);
      checkOutput("issue_wareq", m_wareq, 1);
      checkOutput("issue_grant", grant_id, exp_port);
      checkOutput("issue_addr", m_waddr, model_addr[exp_port]);
      checkOutput("issue_size", m_wsize, model_size[exp_port]);
      checkOutput("issue_sbusy", s_wbusy, one_hot);
      s_wareq[exp_port] = 1'b0;
      repeat ($urandom_range(0, 2)) begin
         @(negedge ui_clk);
         checkOutput("issue_hold", m_wareq, 1);
      end
      m_wbusy = 1'b1;
      @(negedge ui_clk);
      checkOutput("busy_wareq_low", m_wareq, 0);
      checkOutput("busy_sbusy", s_wbusy, one_hot);
      accepted = 0;
      cycles   = 0;
      while (accepted < want) begin
         applyStimulus();
         #1;
         checkOutput("beat_data", m_wdata, s_wdata[exp_port*DATA_WIDTH +: DATA_WIDTH]);
         checkOutput("beat_valid", m_wvalid, s_wvalid[exp_port]);
         checkOutput("beat_ready", s_wready, m_wready ? one_hot : {N_PORTS{1'b0}});
         if (s_wvalid[exp_port] && m_wready) accepted++;
         @(negedge ui_clk);
         cycles++;
         if (cycles > 400) begin
            checkOutput("beat_timeout", 0, 1);
            break;
         end
         if (abort_mid && accepted >= 2) begin
            #2 ui_rst = 1'b1;
            #1;
            checkOutput("abort_wareq", m_wareq, 0);
            checkOutput("abort_wvalid", m_wvalid, 0);
            checkOutput("abort_sbusy", s_wbusy, 0);
            checkOutput("abort_sready", s_wready, 0);
            checkOutput("abort_wdata", m_wdata, 0);
            checkOutput("abort_addr", m_waddr, 0);
            checkOutput("abort_size", m_wsize, 0);
            checkOutput("abort_grant", grant_id, 0);
            checkOutput("abort_err", err_beats, 0);
            clearInputs();
            model_last = N_PORTS - 1;
            model_err  = 1'b0;
            @(negedge ui_clk);
            ui_rst = 1'b0;
            return;
         end
      end
      m_wbusy  = 1'b0;
      s_wvalid = '0;
      m_wready = 1'b0;
      if (accepted != int'(model_size[exp_port])) model_err = 1'b1;
      @(negedge ui_clk);
      checkOutput("done_wareq", m_wareq, 0);
      checkOutput("done_wvalid", m_wvalid, 0);
      checkOutput("done_sbusy", s_wbusy, 0);
      checkOutput("done_sready", s_wready, 0);
      checkOutput("done_err", err_beats, model_err);
      model_last = exp_port;
      @(negedge ui_clk);
      checkOutput("idle_wareq", m_wareq, 0);
   endtask

   // Randomly raise requests on idle ports, keeping at least one pending.
   task automatic randomRequests();
      for (int p = 0; p < N_PORTS; p++) begin
         if (!s_wareq[p] && $urandom_range(0, 1) == 1)
            setRequest(p, ADDR_WIDTH'($urandom), SIZE_WIDTH'($urandom_range(0, 5)));
      end
      if (s_wareq == '0) begin
         setRequest(int'($urandom_range(0, N_PORTS - 1)), ADDR_WIDTH'($urandom),
                    SIZE_WIDTH'($urandom_range(1, 5)));
      end
   endtask

   initial begin
      int g;
      int order [5];
      order = '{0, 1, 2, 3, 0};
      s_waddr = '0;
      s_wsize = '0;
      s_wdata = '0;
      clearInputs();
      for (int p = 0; p < N_PORTS; p++) begin
         model_addr[p] = '0;
         model_size[p] = '0;
      end
      doReset();

      // Single port 2 burst of eight beats
      setRequest(2, 28'h0010000, 16'd8);
      runBurst(-1, 1'b0, g);
      checkOutput("single_err", err_beats, 0);

      // Zero-length burst with nothing accepted keeps the error flag clear
      setRequest(1, 28'h0ABCDE0, 16'd0);
      runBurst(0, 1'b0, g);

      // Contention from reset: all ports requesting continuously
      doReset();
      for (int p = 0; p < N_PORTS; p++)
         setRequest(p, ADDR_WIDTH'($urandom), SIZE_WIDTH'($urandom_range(1, 4)));
      for (int i = 0; i < 5; i++) begin
         runBurst(-1, 1'b0, g);
         checkOutput("contention_order", g, order[i]);
         for (int p = 0; p < N_PORTS; p++)
            if (!s_wareq[p]) setRequest(p, ADDR_WIDTH'($urandom), SIZE_WIDTH'($urandom_range(1, 4)));
      end

      // Isolation: only port 0 requests while all ports toggle valid
      s_wareq = '0;
      model_last = 3;
      doReset();
      setRequest(0, 28'h0123450, 16'd6);
      runBurst(-1, 1'b0, g);

      // Busy gate: channel busy while a request waits in IDLE
      setRequest(1, 28'h0555550, 16'd3);
      m_wbusy = 1'b1;
      repeat (3) begin
         @(negedge ui_clk);
         checkOutput("gate_wareq", m_wareq, 0);
         checkOutput("gate_sbusy", s_wbusy, 0);
      end
      m_wbusy = 1'b0;
      runBurst(-1, 1'b0, g);

      // Randomized traffic
      for (int i = 0; i < 20; i++) begin
         randomRequests();
         runBurst(-1, 1'b0, g);
      end

      // Short burst: size 16 but the channel finishes after 12 beats
      s_wareq = '0;
      setRequest(2, 28'h0FF0000, 16'd16);
      runBurst(12, 1'b0, g);
      checkOutput("mismatch_err", err_beats, 1);
      for (int i = 0; i < 4; i++) begin
         randomRequests();
         runBurst(-1, 1'b0, g);
      end
      checkOutput("sticky_err", err_beats, 1);

      // Reset in the middle of a port 3 burst, then port 0 wins first
      s_wareq = '0;
      setRequest(3, 28'h0333330, 16'd8);
      runBurst(-1, 1'b1, g);
      setRequest(0, 28'h0000100, 16'd2);
      setRequest(3, 28'h0000300, 16'd2);
      runBurst(-1, 1'b0, g);
      checkOutput("post_reset_first", g, 0);
      runBurst(-1, 1'b0, g);
      checkOutput("post_reset_second", g, 3);
      checkOutput("final_err", err_beats, 0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
